// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle of the signals exchanged between the 5-stage pipeline datapath and
// the hazard/sequencing controller.
//
// Pipeline -> controller (hazard sources):
//   id_rs, id_rt          source registers of the instruction in ID
//   id_use_rs, id_use_rt  ID instruction really reads rs / rt
//   ex_r_datamem          EX instruction is a load
//   ex_regfile_w_en       EX instruction writes the register file
//   ex_regfile_req_w      EX destination register
//   ex_branch_taken       branch/jump resolved taken in EX
//   mem_req, mem_ready    data-memory access in MEM and its completion
// Controller -> pipeline (stage control):
//   pc_en                 PC update enable
//   en_ps1..en_ps4        stage-register enables (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   clear_ps1..clear_ps4  stage-register synchronous clears (insert bubble)
//
// Modports: slave = the controller, master = the pipeline datapath.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_r_datamem;
  logic       ex_regfile_w_en;
  logic [4:0] ex_regfile_req_w;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_en;
  logic       en_ps1;
  logic       en_ps2;
  logic       en_ps3;
  logic       en_ps4;
  logic       clear_ps1;
  logic       clear_ps2;
  logic       clear_ps3;
  logic       clear_ps4;

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_r_datamem, ex_regfile_w_en, ex_regfile_req_w, ex_branch_taken,
    input  mem_req, mem_ready,
    output pc_en, en_ps1, en_ps2, en_ps3, en_ps4,
    output clear_ps1, clear_ps2, clear_ps3, clear_ps4
  );

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_r_datamem, ex_regfile_w_en, ex_regfile_req_w, ex_branch_taken,
    output mem_req, mem_ready,
    input  pc_en, en_ps1, en_ps2, en_ps3, en_ps4,
    input  clear_ps1, clear_ps2, clear_ps3, clear_ps4
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencer for the four pipeline stage registers. Inserts load-use
// bubbles, flushes IF/ID and ID/EX on a taken branch/jump, freezes the front
// of the pipe while a data-memory access is outstanding (aborting to HALT on
// timeout), and halts/resumes the core. Keeps saturating counters of
// load-use stalls and branch flushes for the debug bus.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   pipe         pipeline hazard sources in / stage controls out (slave)
//   halt_req_i   single-cycle halt request
//   resume_i     single-cycle resume request
//   halted_o     core is in HALT
//   mem_err_o    one-cycle pulse after a data-memory timeout
//   stall_cnt_o  load-use bubbles inserted (saturating)
//   flush_cnt_o  branch flushes performed (saturating)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_hazard_ctrl_if.slave    pipe,
  input  logic                 halt_req_i,
  input  logic                 resume_i,
  output logic                 halted_o,
  output logic                 mem_err_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              halt_pending_q, halt_pending_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              load_use;
  logic              run_like;

  // r0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign load_use = pipe.ex_r_datamem & pipe.ex_regfile_w_en &
                    (pipe.ex_regfile_req_w != 5'd0) &
                    ((pipe.id_use_rs & (pipe.id_rs == pipe.ex_regfile_req_w)) |
                     (pipe.id_use_rt & (pipe.id_rt == pipe.ex_regfile_req_w)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      to_cnt_q       <= '0;
      halt_pending_q <= 1'b0;
      mem_err_q      <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      halt_pending_q <= halt_pending_d;
      mem_err_q      <= mem_err_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  // run_like marks cycles whose outputs follow the normal RUN rules, including
  // the MEM_WAIT cycle in which memory finally completes; only in those cycles
  // are branch flushes and load-use stalls evaluated and counted.
  always_comb begin
    pipe.pc_en     = 1'b1;
    pipe.en_ps1    = 1'b1;
    pipe.en_ps2    = 1'b1;
    pipe.en_ps3    = 1'b1;
    pipe.en_ps4    = 1'b1;
    pipe.clear_ps1 = 1'b0;
    pipe.clear_ps2 = 1'b0;
    pipe.clear_ps3 = 1'b0;
    pipe.clear_ps4 = 1'b0;
    halted_o       = 1'b0;
    run_like       = 1'b0;
    state_d        = state_q;
    to_cnt_d       = to_cnt_q;
    halt_pending_d = halt_pending_q | halt_req_i;
    mem_err_d      = 1'b0;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;

    case (state_q)
      RUN: begin
        if (pipe.mem_req && !pipe.mem_ready) begin
          pipe.pc_en     = 1'b0;
          pipe.en_ps1    = 1'b0;
          pipe.en_ps2    = 1'b0;
          pipe.en_ps3    = 1'b0;
          pipe.clear_ps4 = 1'b1;
          to_cnt_d       = '0;
          state_d        = MEM_WAIT;
        end else begin
          run_like = 1'b1;
          // The halt is taken from the registered request so that the pipe
          // still advances in this cycle before the core stops.
          if (halt_pending_q) begin
            halt_pending_d = 1'b0;
            state_d        = HALT;
          end
        end
      end

      MEM_WAIT: begin
        if (pipe.mem_ready) begin
          run_like = 1'b1;
          to_cnt_d = '0;
          state_d  = RUN;
        end else begin
          pipe.pc_en     = 1'b0;
          pipe.en_ps1    = 1'b0;
          pipe.en_ps2    = 1'b0;
          pipe.en_ps3    = 1'b0;
          pipe.clear_ps4 = 1'b1;
          if (to_cnt_q == TO_LAST) begin
            // A timeout already lands in HALT, so an outstanding halt request
            // is consumed rather than re-halting right after resume.
            to_cnt_d       = '0;
            mem_err_d      = 1'b1;
            halt_pending_d = 1'b0;
            state_d        = HALT;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      HALT: begin
        pipe.pc_en     = 1'b0;
        pipe.en_ps1    = 1'b0;
        pipe.en_ps2    = 1'b0;
        pipe.en_ps3    = 1'b0;
        pipe.en_ps4    = 1'b0;
        halted_o       = 1'b1;
        halt_pending_d = 1'b0;
        if (resume_i) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // A taken branch discards the younger instructions, so any load-use
    // dependency among them is moot and is not counted as a stall.
    if (run_like) begin
      if (pipe.ex_branch_taken) begin
        pipe.clear_ps1 = 1'b1;
        pipe.clear_ps2 = 1'b1;
        pipe.pc_en     = 1'b1;
        flush_cnt_d    = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
      end else if (load_use) begin
        pipe.pc_en     = 1'b0;
        pipe.en_ps1    = 1'b0;
        pipe.clear_ps2 = 1'b1;
        stall_cnt_d    = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
